// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if
//   Bundles the upstream word handshake, the consumer stall qualifier and the
//   serial output stream of serial_bit_feeder.
//   Parameter WIDTH : bits per parallel word.
//   Signals:
//     in_data/in_valid/in_ready : word handshake (upstream -> feeder)
//     bit_en                    : consumer takes the current bit this cycle
//     x_out/x_valid             : serial bit and its qualifier
//     frame_start/frame_done    : first bit shown / last bit consumed
//     busy                      : a word is held or being shifted
//   Modports: master = upstream + consumer side, slave = the feeder.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             x_out;
  logic             x_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_data, in_valid, bit_en,
    input  in_ready, x_out, x_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  in_data, in_valid, bit_en,
    output in_ready, x_out, x_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Parallel-to-serial front end. Words arrive through a valid/ready
//   handshake into a one-word holding buffer; a shift register streams them
//   out one bit per consumed clock. The holding buffer refills while a word
//   is shifting, so back-to-back words leave with no gap cycle.
//   Parameters:
//     WIDTH     : bits per word (>= 2)
//     MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//     IDLE_BIT  : level on x_out while nothing is being shifted
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : serial_bit_feeder_if.slave (handshake, stall, serial stream)
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic                clk,
  input logic                rst,
  serial_bit_feeder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;

  logic [WIDTH-1:0] sh_shifted;
  logic             accept;
  logic             last_take;
  logic             load;
  logic             out_bit;

  // One-place shift toward the output end; the vacated end fills with 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_fill
        assign sh_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sh_shifted[gi] = sh_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_fill
        assign sh_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sh_shifted[gi] = sh_reg[gi+1];
      end
    end
  end

  assign out_bit = MSB_FIRST ? sh_reg[WIDTH-1] : sh_reg[0];

  // in_ready comes straight from the hold flag so upstream never sees a
  // combinational path from bit_en or in_valid.
  assign accept    = bus.in_valid & ~hold_full_reg;
  assign last_take = (state_reg == SHIFT) & bus.bit_en & (bit_cnt_reg == LAST_CNT);
  assign load      = hold_full_reg & ((state_reg == IDLE) | last_take);

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    sh_next        = sh_reg;
    bit_cnt_next   = bit_cnt_reg;

    // Accept and load are mutually exclusive: accept needs an empty buffer,
    // load needs a full one.
    if (accept) begin
      hold_next      = bus.in_data;
      hold_full_next = 1'b1;
    end

    if (load) begin
      sh_next        = hold_reg;
      bit_cnt_next   = '0;
      state_next     = SHIFT;
      hold_full_next = 1'b0;
    end else if (last_take) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
    end else if ((state_reg == SHIFT) && bus.bit_en) begin
      sh_next      = sh_shifted;
      bit_cnt_next = bit_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      sh_reg        <= '0;
      bit_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      sh_reg        <= sh_next;
      bit_cnt_reg   <= bit_cnt_next;
    end
  end

  assign bus.in_ready    = ~hold_full_reg;
  assign bus.x_valid     = (state_reg == SHIFT);
  // Idle line is driven to IDLE_BIT so a consumer that samples every clock
  // does not see stale shift-register contents as data.
  assign bus.x_out       = (state_reg == SHIFT) ? out_bit : IDLE_BIT;
  assign bus.frame_start = (state_reg == SHIFT) & (bit_cnt_reg == '0);
  assign bus.frame_done  = last_take;
  assign bus.busy        = hold_full_reg | (state_reg == SHIFT);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder
//   Directed bench for serial_bit_feeder. A queue-driven upstream process
//   presents words and holds them until accepted; the main process steps
//   the consumer (bit_en) and records per-cycle output traces, which are
//   compared against hand-computed bit patterns (oldest cycle = MSB).
//   A second instance covers WIDTH=4, LSB-first, IDLE_BIT=1.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(8)) bus ();
  serial_bit_feeder_if #(.WIDTH(4)) bus6 ();

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] word_q[$];
  int         n_acc = 0;

  logic [31:0] cap_x, cap_v, cap_fs, cap_fd, cap_rdy, cap_busy, cap_tk;
  int          n_tk;
  int          acc0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Upstream: presents the queue head with in_valid and holds it until the
  // handshake completes on a clock edge.
  initial begin : upstream
    bit         acc;
    logic [7:0] w;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready & ~rst;
      @(posedge clk);
      #1;
      if (acc) begin
        w = word_q.pop_front();
        $display("accept #%0d word %h at %0t", n_acc, w, $time);
        n_acc++;
      end
      if (word_q.size() != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = word_q[0];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  end

  // Runs n cycles; bit_en for cycle i is en[n-1-i]. Traces shift in at LSB.
  task automatic run(input int n, input logic [31:0] en);
    cap_x = '0; cap_v = '0; cap_fs = '0; cap_fd = '0;
    cap_rdy = '0; cap_busy = '0; cap_tk = '0; n_tk = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.bit_en = en[n-1-i];
      @(negedge clk);
      cap_x    = {cap_x[30:0],    bus.x_out};
      cap_v    = {cap_v[30:0],    bus.x_valid};
      cap_fs   = {cap_fs[30:0],   bus.frame_start};
      cap_fd   = {cap_fd[30:0],   bus.frame_done};
      cap_rdy  = {cap_rdy[30:0],  bus.in_ready};
      cap_busy = {cap_busy[30:0], bus.busy};
      if (bus.x_valid && bus.bit_en) begin
        cap_tk = {cap_tk[30:0], bus.x_out};
        n_tk++;
      end
    end
  endtask

  initial begin : main
    logic [7:0] c6x, c6v, c6fd;
    rst = 1'b1;
    bus.bit_en    = 1'b0;
    bus6.in_valid = 1'b0;
    bus6.in_data  = '0;
    bus6.bit_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready",    32'(bus.in_ready),    32'd1);
    check_eq("rst_x_valid",     32'(bus.x_valid),     32'd0);
    check_eq("rst_x_out",       32'(bus.x_out),       32'd0);
    check_eq("rst_frame_start", 32'(bus.frame_start), 32'd0);
    check_eq("rst_frame_done",  32'(bus.frame_done),  32'd0);
    check_eq("rst_busy",        32'(bus.busy),        32'd0);
    check_eq("rst6_x_out",      32'(bus6.x_out),      32'd1);
    check_eq("rst6_in_ready",   32'(bus6.in_ready),   32'd1);

    // 1: single word 0x88, first bit two cycles after the accept edge.
    acc0 = n_acc;
    word_q.push_back(8'h88);
    run(11, '1);
    check_eq("t1_x_out",   cap_x,    32'(11'b00_10001000_0));
    check_eq("t1_x_valid", cap_v,    32'(11'b00_11111111_0));
    check_eq("t1_fstart",  cap_fs,   32'(11'b00_10000000_0));
    check_eq("t1_fdone",   cap_fd,   32'(11'b00_00000001_0));
    check_eq("t1_ready",   cap_rdy,  32'(11'b10_11111111_1));
    check_eq("t1_busy",    cap_busy, 32'(11'b01_11111111_0));
    check_eq("t1_taken",   cap_tk,   32'h88);
    check_eq("t1_acc",     32'(n_acc - acc0), 32'd1);

    // 2: back-to-back 0x88, 0xF0; refill accepted mid-shift, no gap.
    acc0 = n_acc;
    word_q.push_back(8'h88);
    word_q.push_back(8'hF0);
    run(19, '1);
    check_eq("t2_x_out",   cap_x,   32'(19'b00_10001000_11110000_0));
    check_eq("t2_x_valid", cap_v,   32'(19'b00_11111111_11111111_0));
    check_eq("t2_fstart",  cap_fs,  32'(19'b00_10000000_10000000_0));
    check_eq("t2_fdone",   cap_fd,  32'(19'b00_00000001_00000001_0));
    check_eq("t2_ready",   cap_rdy, 32'(19'b10_10000000_11111111_1));
    check_eq("t2_taken",   cap_tk,  32'h88F0);
    check_eq("t2_acc",     32'(n_acc - acc0), 32'd2);

    // 3: 0xA5 with a 3-cycle stall while the 2nd bit is shown.
    word_q.push_back(8'hA5);
    run(14, 32'(14'b111_000_11111111));
    check_eq("t3_x_out",  cap_x,  32'(14'b00100001001010));
    check_eq("t3_fstart", cap_fs, 32'(14'b00100000000000));
    check_eq("t3_fdone",  cap_fd, 32'(14'b00000000000010));
    check_eq("t3_taken",  cap_tk, 32'hA5);
    check_eq("t3_ntaken", 32'(n_tk), 32'd8);

    // 4: three words under backpressure; nothing lost or duplicated.
    acc0 = n_acc;
    word_q.push_back(8'h01);
    word_q.push_back(8'h02);
    word_q.push_back(8'h03);
    run(27, '1);
    check_eq("t4_ready",   cap_rdy, 32'(27'b1_0_1_0000000_1_0000000_111111111));
    check_eq("t4_x_valid", cap_v,   32'(27'b00_111111111111111111111111_0));
    check_eq("t4_taken",   cap_tk,  32'h010203);
    check_eq("t4_ntaken",  32'(n_tk), 32'd24);
    check_eq("t4_acc",     32'(n_acc - acc0), 32'd3);

    // 5: reset during the 4th bit of 0xFF with 0x81 held.
    word_q.push_back(8'hFF);
    word_q.push_back(8'h81);
    run(5, '1);
    check_eq("t5_pre_x_out", cap_x,   32'(5'b00111));
    check_eq("t5_pre_ready", cap_rdy, 32'(5'b10100));
    check_eq("t5_pre_fdone", cap_fd,  32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t5_bit4_valid", 32'(bus.x_valid),  32'd1);
    check_eq("t5_bit4_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t5_post_x_valid", 32'(bus.x_valid),    32'd0);
    check_eq("t5_post_busy",    32'(bus.busy),       32'd0);
    check_eq("t5_post_ready",   32'(bus.in_ready),   32'd1);
    check_eq("t5_post_x_out",   32'(bus.x_out),      32'd0);
    check_eq("t5_post_fdone",   32'(bus.frame_done), 32'd0);
    word_q.push_back(8'h5A);
    run(11, '1);
    check_eq("t5_x_out",  cap_x,  32'(11'b00_01011010_0));
    check_eq("t5_fstart", cap_fs, 32'(11'b00_10000000_0));
    check_eq("t5_fdone",  cap_fd, 32'(11'b00_00000001_0));
    check_eq("t5_taken",  cap_tk, 32'h5A);
    check_eq("t5_ntaken", 32'(n_tk), 32'd8);

    // 6: WIDTH=4, LSB first, idle level 1.
    @(posedge clk);
    #1 bus6.bit_en = 1'b0;
    @(negedge clk);
    check_eq("t6_idle_stall_x_out", 32'(bus6.x_out),   32'd1);
    check_eq("t6_idle_x_valid",     32'(bus6.x_valid), 32'd0);
    @(posedge clk);
    #1;
    bus6.in_valid = 1'b1;
    bus6.in_data  = 4'b0001;
    @(negedge clk);
    check_eq("t6_ready", 32'(bus6.in_ready), 32'd1);
    c6x = '0; c6v = '0; c6fd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus6.in_valid = 1'b0;
      bus6.bit_en   = (i < 6);
      @(negedge clk);
      c6x  = {c6x[6:0],  bus6.x_out};
      c6v  = {c6v[6:0],  bus6.x_valid};
      c6fd = {c6fd[6:0], bus6.frame_done};
    end
    check_eq("t6_x_out",   32'(c6x),  32'(8'b11000111));
    check_eq("t6_x_valid", 32'(c6v),  32'(8'b01111000));
    check_eq("t6_fdone",   32'(c6fd), 32'(8'b00001000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Parallel-to-serial front end that turns WIDTH-bit words into the one-bit-per-clock stream consumed by the pattern/sequence detectors. Upstream accepts words through a valid/ready handshake. A one-word holding buffer plus a shift register stream back-to-back words with no bubble. A bit_en qualifier lets the consumer stall the stream.

Parameters:
WIDTH, 8, bits per input word; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_BIT, 0, level driven on x_out while no word is being shifted.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  WIDTH  parallel word from upstream
in_valid  input  1  in_data is valid
in_ready  output  1  feeder can accept a word this cycle
bit_en  input  1  consumer takes the current bit this cycle
x_out  output  1  serial bit to the detector
x_valid  output  1  x_out carries a real data bit
frame_start  output  1  current x_out is bit 0 of a word (first shifted)
frame_done  output  1  last bit of a word is consumed this cycle
busy  output  1  a word is held or being shifted

Behaviour:
- Interface decision: one clock, clk; rst is synchronous and active-high; all registers are cleared on the rst edge.
- Registers:
  - hold_reg[WIDTH] and hold_full
  - sh_reg[WIDTH]
  - bit_cnt, width ceil(log2(WIDTH))
  - state, one of IDLE or SHIFT
- Reset values: hold_full=0, state=IDLE, bit_cnt=0, sh_reg=0.
- Outputs after reset: in_ready=1, x_valid=0, x_out=IDLE_BIT, frame_start=0, frame_done=0, busy=0.
- in_ready = ~hold_full, taken from the register only, with no combinational path from bit_en or in_valid.
- Accept: when in_valid & in_ready, then hold_reg<=in_data and hold_full<=1. While in_valid=0, in_data is ignored.
- Define load = hold_full & (state==IDLE | last_take).
  - last_take = (state==SHIFT) & bit_en & (bit_cnt==WIDTH-1).
- On load:
  - sh_reg<=hold_reg, bit_cnt<=0, state<=SHIFT, hold_full<=0.
  - A load and an accept cannot occur in the same cycle, because in_ready=0 while hold_full=1.
- SHIFT with bit_en=1 and bit_cnt<WIDTH-1: shift sh_reg one place toward the output end and increment bit_cnt.
- SHIFT with bit_en=0: all state holds and x_out is stable.
- last_take with hold_full=0: state<=IDLE and bit_cnt<=0.
- x_valid = (state==SHIFT).
- x_out:
  - In SHIFT, x_out = sh_reg[WIDTH-1] if MSB_FIRST, else sh_reg[0].
  - In IDLE, x_out = IDLE_BIT.
- frame_start = x_valid & (bit_cnt==0).
- frame_done = last_take.
- busy = hold_full | (state==SHIFT).
- Latency: word accepted on edge N, then hold_full=1 in cycle N+1. If IDLE, it loads on edge N+1, so x_valid=1 with the first bit in cycle N+2.
- Throughput:
  - With bit_en held high and in_valid held high, the upstream sees one accept every WIDTH cycles.
  - x_valid stays continuously high and there are no gap cycles between words.
  - This holds because a refill is accepted during the shift, given WIDTH >= 2.
- Backpressure: with hold_full=1, in_ready=0 and in_data may change without effect. Upstream must hold in_valid/in_data until accepted.
- Reset mid-frame: the partial word and any held word are discarded. Next cycle x_valid=0 and x_out=IDLE_BIT. No frame_done is produced for the aborted word.
- Consumer tying bit_en=1 and sampling x_out every clock sees IDLE_BIT in idle cycles; this is intentional, so an idle line does not fabricate a pattern when IDLE_BIT=0 is non-matching.

Test Plan:
1. Reset, then send in_data=8'h88 (MSB_FIRST=1, bit_en=1):
   - x_out sequence is 1,0,0,0,1,0,0,0 over cycles N+2..N+9.
   - frame_start is high in cycle N+2 only; frame_done is high in cycle N+9 only.
   - x_out=0 and x_valid=0 from N+10.
2. Back-to-back 8'h88 then 8'hF0 with in_valid held:
   - 16 contiguous x_valid cycles, bits 10001000 11110000.
   - Second accept occurs while the first word is still shifting.
   - in_ready is low from the second accept until the second load.
3. Stall: during word 8'hA5, drop bit_en for 3 cycles after the 2nd bit:
   - x_out holds 0 (the 2nd bit) for all stall cycles and bit_cnt holds.
   - The full sequence is still 10100101; frame_done is delayed by exactly 3 cycles.
4. Backpressure: present 3 words 8'h01, 8'h02, 8'h03 with in_valid constant:
   - in_ready deasserts while hold_full=1.
   - No word is lost or duplicated; the output stream is 00000001 00000010 00000011.
5. Reset asserted in the 4th bit of 8'hFF with 8'h81 held:
   - The cycle after the rst edge shows x_valid=0, busy=0, in_ready=1, x_out=IDLE_BIT.
   - The next accepted word streams cleanly from bit 0.
6. MSB_FIRST=0, IDLE_BIT=1, WIDTH=4, word 4'b0001:
   - Output is 1,0,0,0.
   - x_out=1 both in idle cycles and while stalled in IDLE.
